// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard detection / forwarding unit.
//   trk_entry_t : one destination-tracker slot (valid, wen, wnum, is_load)
//   ZERO_REG    : register number that is hardwired to zero
//   STG_*       : tracker stage indices (1 = EX, 2 = MEM, 3 = WB)
//   MAX_REG_AW  : storage width of wnum; REG_AW of the unit must not exceed it
package hazard_pkg;

  localparam int MAX_REG_AW = 8;
  localparam int ZERO_REG   = 0;

  localparam int STG_EX  = 1;
  localparam int STG_MEM = 2;
  localparam int STG_WB  = 3;

  // Register numbers are stored zero-extended to MAX_REG_AW so that one
  // packed type serves every REG_AW setting.
  typedef struct packed {
    logic                  valid;
    logic                  wen;
    logic [MAX_REG_AW-1:0] wnum;
    logic                  is_load;
  } trk_entry_t;

endpackage

// File: rtl/fwd_port_select.sv
// Priority match for one ID read port against the destination tracker.
// Ports:
//   ren, rnum : read enable and register number of this port
//   trk       : tracker, trk[k-1] holds stage k (k = 1 is the youngest)
//   hit       : some tracked instruction writes rnum
//   sel       : stage index (1..PIPE_DEPTH) of the youngest writer, 0 on no hit
//   load_nr   : the youngest writer is a load whose data is not yet valid
module fwd_port_select
  import hazard_pkg::*;
#(
  parameter int REG_AW     = 5,
  parameter int PIPE_DEPTH = 3,
  parameter int LOAD_READY = 2,
  parameter int SEL_W      = $clog2(PIPE_DEPTH + 1)
) (
  input  logic                        ren,
  input  logic [REG_AW-1:0]           rnum,
  input  trk_entry_t [PIPE_DEPTH-1:0] trk,
  output logic                        hit,
  output logic [SEL_W-1:0]            sel,
  output logic                        load_nr
);

  // Scan oldest to youngest so a younger match overwrites an older one.
  always_comb begin
    hit     = 1'b0;
    sel     = '0;
    load_nr = 1'b0;
    if (ren && (rnum != REG_AW'(ZERO_REG))) begin
      for (int k = PIPE_DEPTH; k >= 1; k--) begin
        if (trk[k-1].valid && trk[k-1].wen &&
            (trk[k-1].wnum == MAX_REG_AW'(rnum))) begin
          hit     = 1'b1;
          sel     = SEL_W'(k);
          load_nr = trk[k-1].is_load && (k < LOAD_READY);
        end
      end
    end
  end

endmodule

// File: rtl/hazard_fwd_unit.sv
// Hazard detection and operand forwarding for the ID stage.
// Tracks the destinations of the last PIPE_DEPTH issued instructions, forwards
// the youngest in-flight result to each read port, and stalls ID on a
// load-use dependence whose data is not yet available.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   id_valid/ren/rnum/rdata: ID instruction and its regfile read ports
//   id_wen/wnum/is_load   : destination info of the ID instruction
//   flush                 : kill the ID instruction (bubble enters stage 1)
//   halt                  : freeze tracker and stall counter
//   stage_data            : in-flight results, stage k at [(k-1)*DATA_W +: DATA_W]
//   bypass_data, fwd_hit  : per-port operand and forward indication
//   stall                 : hold PC and IF/ID, bubble into ID/EX
//   stall_cnt             : saturating stall-cycle counter
module hazard_fwd_unit
  import hazard_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int REG_AW      = 5,
  parameter int NUM_RD      = 2,
  parameter int PIPE_DEPTH  = 3,
  parameter int LOAD_READY  = 2,
  parameter int STALL_CNT_W = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         id_valid,
  input  logic [NUM_RD-1:0]            id_ren,
  input  logic [NUM_RD*REG_AW-1:0]     id_rnum,
  input  logic [NUM_RD*DATA_W-1:0]     id_rdata,
  input  logic                         id_wen,
  input  logic [REG_AW-1:0]            id_wnum,
  input  logic                         id_is_load,
  input  logic                         flush,
  input  logic                         halt,
  input  logic [PIPE_DEPTH*DATA_W-1:0] stage_data,
  output logic [NUM_RD*DATA_W-1:0]     bypass_data,
  output logic [NUM_RD-1:0]            fwd_hit,
  output logic                         stall,
  output logic [STALL_CNT_W-1:0]       stall_cnt
);

  localparam int SEL_W = $clog2(PIPE_DEPTH + 1);

  trk_entry_t [PIPE_DEPTH-1:0] trk_q, trk_d;
  logic [STALL_CNT_W-1:0]      stall_cnt_q, stall_cnt_d;

  logic [NUM_RD-1:0] hit;
  logic [NUM_RD-1:0] load_nr;
  logic [SEL_W-1:0]  sel [NUM_RD];

  function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] v);
    return (&v) ? v : v + STALL_CNT_W'(1);
  endfunction

  for (genvar p = 0; p < NUM_RD; p++) begin : g_port
    fwd_port_select #(
      .REG_AW    (REG_AW),
      .PIPE_DEPTH(PIPE_DEPTH),
      .LOAD_READY(LOAD_READY),
      .SEL_W     (SEL_W)
    ) u_sel (
      .ren    (id_ren[p]),
      .rnum   (id_rnum[p*REG_AW +: REG_AW]),
      .trk    (trk_q),
      .hit    (hit[p]),
      .sel    (sel[p]),
      .load_nr(load_nr[p])
    );
  end

  // A not-ready load leaves the port un-forwarded; its operand is don't-care
  // because the stall turns the ID/EX slot into a bubble.
  always_comb begin
    bypass_data = id_rdata;
    fwd_hit     = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      if (hit[p] && !load_nr[p]) begin
        fwd_hit[p] = 1'b1;
        for (int k = 1; k <= PIPE_DEPTH; k++) begin
          if (sel[p] == SEL_W'(k)) begin
            bypass_data[p*DATA_W +: DATA_W] = stage_data[(k-1)*DATA_W +: DATA_W];
          end
        end
      end
    end
  end

  assign stall     = id_valid & (|load_nr);
  assign stall_cnt = stall_cnt_q;

  // Halt freezes everything; otherwise the tracker advances one stage and a
  // stalled or flushed ID instruction enters as a bubble.
  always_comb begin
    trk_d       = trk_q;
    stall_cnt_d = stall_cnt_q;
    if (!halt) begin
      for (int k = PIPE_DEPTH - 1; k >= 1; k--) begin
        trk_d[k] = trk_q[k-1];
      end
      trk_d[0].valid   = id_valid & ~stall & ~flush;
      trk_d[0].wen     = id_wen;
      trk_d[0].wnum    = MAX_REG_AW'(id_wnum);
      trk_d[0].is_load = id_is_load;
      if (stall) begin
        stall_cnt_d = sat_inc(stall_cnt_q);
      end
    end
  end

  // ---- tracker / counter register boundary ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trk_q       <= '0;
      stall_cnt_q <= '0;
    end else begin
      trk_q       <= trk_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_fwd_unit.sv
module tb_hazard_fwd_unit;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int PD = 3;
  localparam int LR = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              id_valid;
  logic [NR-1:0]     id_ren;
  logic [NR*AW-1:0]  id_rnum;
  logic [NR*DW-1:0]  id_rdata;
  logic              id_wen;
  logic [AW-1:0]     id_wnum;
  logic              id_is_load;
  logic              flush;
  logic              halt;
  logic [DW-1:0]     sd [1:PD];
  logic [PD*DW-1:0]  stage_data;
  assign stage_data = {sd[3], sd[2], sd[1]};

  logic [NR*DW-1:0]  bypass_data, bypass_s;
  logic [NR-1:0]     fwd_hit, hit_s;
  logic              stall, stall_s;
  logic [31:0]       stall_cnt;
  logic [1:0]        cnt_s;

  hazard_fwd_unit #(.DATA_W(DW), .REG_AW(AW), .NUM_RD(NR), .PIPE_DEPTH(PD),
                    .LOAD_READY(LR), .STALL_CNT_W(32)) u_dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ren(id_ren),
    .id_rnum(id_rnum), .id_rdata(id_rdata), .id_wen(id_wen), .id_wnum(id_wnum),
    .id_is_load(id_is_load), .flush(flush), .halt(halt), .stage_data(stage_data),
    .bypass_data(bypass_data), .fwd_hit(fwd_hit), .stall(stall), .stall_cnt(stall_cnt)
  );

  hazard_fwd_unit #(.DATA_W(DW), .REG_AW(AW), .NUM_RD(NR), .PIPE_DEPTH(PD),
                    .LOAD_READY(LR), .STALL_CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ren(id_ren),
    .id_rnum(id_rnum), .id_rdata(id_rdata), .id_wen(id_wen), .id_wnum(id_wnum),
    .id_is_load(id_is_load), .flush(flush), .halt(halt), .stage_data(stage_data),
    .bypass_data(bypass_s), .fwd_hit(hit_s), .stall(stall_s), .stall_cnt(cnt_s)
  );

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    bit v;
    bit wen;
    int wnum;
    bit ld;
  } ment_t;

  ment_t   m [1:PD];
  longint  cnt32;
  int      cnt2;

  function automatic void mport(input int p, output bit dc, output bit hit,
                                output logic [DW-1:0] d);
    int rn;
    rn  = int'(id_rnum[p*AW +: AW]);
    dc  = 0;
    hit = 0;
    d   = id_rdata[p*DW +: DW];
    if (id_ren[p] && rn != 0) begin
      for (int k = 1; k <= PD; k++) begin
        if (m[k].v && m[k].wen && m[k].wnum == rn) begin
          if (m[k].ld && k < LR) dc = 1;
          else begin
            hit = 1;
            d   = stage_data[(k-1)*DW +: DW];
          end
          break;
        end
      end
    end
  endfunction

  function automatic bit mstall();
    bit dc, h;
    logic [DW-1:0] d;
    bit any;
    any = 0;
    for (int p = 0; p < NR; p++) begin
      mport(p, dc, h, d);
      if (dc) any = 1;
    end
    return id_valid && any;
  endfunction

  task automatic mclear();
    for (int k = 1; k <= PD; k++) m[k] = '{0, 0, 0, 0};
    cnt32 = 0;
    cnt2  = 0;
  endtask

  initial begin
    bit st;
    mclear();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) mclear();
      else if (!halt) begin
        st = mstall();
        for (int k = PD; k >= 2; k--) m[k] = m[k-1];
        m[1].v    = id_valid && !st && !flush;
        m[1].wen  = id_wen;
        m[1].wnum = int'(id_wnum);
        m[1].ld   = id_is_load;
        if (st) begin
          if (cnt32 != 64'hFFFF_FFFF) cnt32++;
          if (cnt2 != 3) cnt2++;
        end
      end
    end
  end

  // Per-cycle comparison against the model.
  initial begin
    bit dc, h, est;
    logic [DW-1:0] d;
    forever begin
      @(negedge clk);
      est = mstall();
      chk("stall", 64'(stall), 64'(est));
      chk("stall_s", 64'(stall_s), 64'(est));
      chk("stall_cnt", 64'(stall_cnt), 64'(cnt32));
      chk("stall_cnt_w2", 64'(cnt_s), 64'(cnt2));
      for (int p = 0; p < NR; p++) begin
        mport(p, dc, h, d);
        if (!dc) begin
          chk($sformatf("fwd_hit[%0d]", p), 64'(fwd_hit[p]), 64'(h));
          chk($sformatf("bypass[%0d]", p), 64'(bypass_data[p*DW +: DW]), 64'(d));
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle();
    id_valid = 0; id_ren = '0; id_rnum = '0; id_rdata = '0;
    id_wen = 0; id_wnum = '0; id_is_load = 0; flush = 0; halt = 0;
  endtask

  task automatic issue(input int wn, input bit ld);
    id_valid = 1; id_wen = 1; id_wnum = AW'(wn); id_is_load = ld;
    id_ren = '0;
  endtask

  task automatic rd(input int p, input int rn, input logic [DW-1:0] rdv);
    id_ren[p] = 1'b1;
    id_rnum[p*AW +: AW] = AW'(rn);
    id_rdata[p*DW +: DW] = rdv;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
    #1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    idle();
    for (int k = 1; k <= PD; k++) sd[k] = '0;

    // Reset state
    rd(0, 8, 32'h11); rd(1, 8, 32'h22);
    at_neg();
    chk("rst_stall", 64'(stall), 64'd0);
    chk("rst_cnt", 64'(stall_cnt), 64'd0);
    chk("rst_hit", 64'(fwd_hit), 64'd0);
    chk("rst_byp0", 64'(bypass_data[DW-1:0]), 64'h11);
    rst_n = 1'b1;
    step();

    // ALU chain
    idle(); issue(8, 0);
    step();
    idle(); id_valid = 1; rd(0, 8, 32'hAAAA); sd[1] = 32'h15;
    at_neg();
    chk("alu_hit0", 64'(fwd_hit[0]), 64'd1);
    chk("alu_byp0", 64'(bypass_data[DW-1:0]), 64'h15);
    chk("alu_stall", 64'(stall), 64'd0);
    step();

    // Load-use
    idle(); issue(9, 1);
    step();
    idle(); id_valid = 1; rd(1, 9, 32'h5555); sd[2] = 32'h0;
    at_neg();
    chk("lu_stall", 64'(stall), 64'd1);
    step();
    sd[2] = 32'hCAFE;
    at_neg();
    chk("lu_cnt", 64'(stall_cnt), 64'd1);
    chk("lu_stall_after", 64'(stall), 64'd0);
    chk("lu_byp1", 64'(bypass_data[2*DW-1:DW]), 64'hCAFE);
    chk("lu_hit1", 64'(fwd_hit[1]), 64'd1);
    step();

    // Priority: r5 at stages 3 and 1, r6 at stage 2
    idle(); issue(5, 0); step();
    idle(); issue(6, 0); step();
    idle(); issue(5, 0); step();
    idle(); id_valid = 1; rd(0, 5, 32'h77); rd(1, 6, 32'h88);
    sd[1] = 32'h1; sd[2] = 32'h2; sd[3] = 32'h3;
    at_neg();
    chk("prio_byp0", 64'(bypass_data[DW-1:0]), 64'h1);
    chk("prio_byp1", 64'(bypass_data[2*DW-1:DW]), 64'h2);
    step();

    // Register zero
    idle(); issue(0, 0); step();
    idle(); id_valid = 1; rd(0, 0, 32'h0); sd[1] = 32'hDEAD;
    at_neg();
    chk("r0_hit", 64'(fwd_hit[0]), 64'd0);
    chk("r0_byp", 64'(bypass_data[DW-1:0]), 64'h0);
    step();

    // Flush kills the ID instruction
    idle(); issue(12, 0); flush = 1; step();
    idle(); id_valid = 1; rd(0, 12, 32'h77); sd[1] = 32'h99;
    at_neg();
    chk("flush_hit", 64'(fwd_hit[0]), 64'd0);
    chk("flush_byp", 64'(bypass_data[DW-1:0]), 64'h77);
    step();

    // Halt during a load-use stall: nothing moves, counter holds
    idle(); issue(14, 1); step();
    idle(); id_valid = 1; rd(0, 14, 32'h0); halt = 1;
    repeat (4) step();
    at_neg();
    chk("halt_cnt", 64'(stall_cnt), 64'd1);
    chk("halt_stall", 64'(stall), 64'd1);
    halt = 0;
    step();
    sd[2] = 32'hBEEF;
    at_neg();
    chk("unhalt_cnt", 64'(stall_cnt), 64'd2);
    chk("unhalt_stall", 64'(stall), 64'd0);
    chk("unhalt_byp0", 64'(bypass_data[DW-1:0]), 64'hBEEF);
    step();

    // Flush + stall together: stall still counts
    idle(); issue(16, 1); step();
    idle(); id_valid = 1; rd(0, 16, 32'h0); flush = 1;
    step();
    idle();
    at_neg();
    chk("fs_cnt", 64'(stall_cnt), 64'd3);
    step();

    // Reset asserted mid-stall
    idle(); issue(15, 1); step();
    idle(); id_valid = 1; rd(0, 15, 32'h4242);
    at_neg();
    chk("pre_rst_stall", 64'(stall), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_stall", 64'(stall), 64'd0);
    chk("mid_rst_cnt", 64'(stall_cnt), 64'd0);
    chk("mid_rst_cnt_s", 64'(cnt_s), 64'd0);
    chk("mid_rst_hit", 64'(fwd_hit), 64'd0);
    chk("mid_rst_byp", 64'(bypass_data[DW-1:0]), 64'h4242);
    step();
    rst_n = 1'b1;
    step();

    // Five stalls: narrow counter saturates at 3
    for (int i = 0; i < 5; i++) begin
      idle(); issue(20, 1); step();
      idle(); id_valid = 1; rd(0, 20, 32'h0); sd[2] = 32'h20 + DW'(i);
      step();
      step();
    end
    idle();
    at_neg();
    chk("sat_cnt_w2", 64'(cnt_s), 64'd3);
    chk("sat_cnt_w32", 64'(stall_cnt), 64'd5);
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
